// File: rtl/cic_pkg.sv
// Shared constants and helpers for the multi-channel CIC decimator: accumulator
// sizing, rate clamping and signed saturation.
package cic_pkg;

  localparam int SAT_W = 64;

  // Bits needed to hold the worst-case CIC growth (RMAX*M)**N on top of the input.
  function automatic int reg_width(input int width, input int rmax, input int m, input int n);
    longint gain;
    gain = 1;
    for (int i = 0; i < n; i++) begin
      gain = gain * longint'(rmax * m);
    end
    return width + $clog2(gain);
  endfunction

  function automatic int clamp_rate(input int r, input int rmax);
    if (r < 1) return 1;
    if (r > rmax) return rmax;
    return r;
  endfunction

  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_decimator_mc_if.sv
// Stream bundle for the CIC decimator: input samples, decimated output and
// the runtime rate/shift controls.
interface cic_decimator_mc_if #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int OUT_WIDTH = 16,
  parameter int RATE_W    = 4,
  parameter int SHIFT_W   = 5
);
  // A beat transfers on a clock edge where tvalid && tready; once tvalid is raised,
  // tdata holds steady and tvalid stays high until that transfer happens.
  logic [CHANNELS*WIDTH-1:0]     input_tdata;
  logic                          input_tvalid;
  logic                          input_tready;
  logic [CHANNELS*OUT_WIDTH-1:0] output_tdata;
  logic                          output_tvalid;
  logic                          output_tready;
  logic [RATE_W-1:0]             rate;
  logic [SHIFT_W-1:0]            shift;

  modport slave (
    input  input_tdata, input_tvalid, output input_tready,
    output output_tdata, output_tvalid, input output_tready,
    input  rate, input shift
  );

  modport master (
    output input_tdata, output input_tvalid, input input_tready,
    input  output_tdata, input output_tvalid, output output_tready,
    output rate, output shift
  );
endinterface

// File: rtl/cic_lane.sv
// One CIC lane: N wrapping integrators at the input rate, N comb stages with
// M-deep delays at the decimated rate, then shift and saturate.
module cic_lane
  import cic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int M         = 1,
  parameter int N         = 3,
  parameter int OUT_WIDTH = 16,
  parameter int REG_WIDTH = 25,
  parameter int SHIFT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_en,
  input  logic                 dec_en,
  input  logic [WIDTH-1:0]     sample,
  input  logic [SHIFT_W-1:0]   shift,
  output logic [OUT_WIDTH-1:0] result
);

  logic signed [REG_WIDTH-1:0] integ [N];
  logic signed [REG_WIDTH-1:0] sample_ext;
  logic signed [REG_WIDTH-1:0] comb_out;
  logic signed [REG_WIDTH-1:0] shifted;

  assign sample_ext = REG_WIDTH'(signed'(sample));

  // Integrator overflow is harmless: the comb differences recover the true value mod 2^REG_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
    end else if (in_en) begin
      integ[0] <= integ[0] + sample_ext;
      for (int k = 1; k < N; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic signed [REG_WIDTH-1:0] x;
    logic signed [REG_WIDTH-1:0] y;
    logic signed [REG_WIDTH-1:0] dly [M];

    if (k == 0) begin : g_first
      assign x = integ[N-1];
    end else begin : g_next
      assign x = g_comb[k-1].y;
    end

    assign y = x - dly[M-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < M; j++) dly[j] <= '0;
      end else if (dec_en) begin
        dly[0] <= x;
        for (int j = 1; j < M; j++) dly[j] <= dly[j-1];
      end
    end
  end

  assign comb_out = g_comb[N-1].y;
  assign shifted  = comb_out >>> shift;
  assign result   = OUT_WIDTH'(saturate(SAT_W'(shifted), OUT_WIDTH));

endmodule

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: shared frame counter, rate latch, ready/valid
// handshake and a single-word output register over CHANNELS lanes.
module cic_decimator_mc
  import cic_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int RMAX      = 8,
  parameter int M         = 1,
  parameter int N         = 3,
  parameter int OUT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  cic_decimator_mc_if.slave s
);

  localparam int REG_WIDTH = reg_width(WIDTH, RMAX, M, N);
  localparam int RATE_W    = $clog2(RMAX + 1);
  localparam int SHIFT_W   = $clog2(REG_WIDTH);

  logic [RATE_W-1:0]             cycle_cnt;
  logic [RATE_W-1:0]             rate_q;
  logic [RATE_W-1:0]             rate_clamped;
  logic [RATE_W-1:0]             rate_eff;
  logic                          last_pos;
  logic                          accept;
  logic                          dec_ev;
  logic                          out_valid;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data;
  logic [CHANNELS*OUT_WIDTH-1:0] lane_result;

  // The first sample of a frame already uses the freshly latched rate, so a
  // rate of 1 closes its frame on that same sample.
  assign rate_clamped = RATE_W'(clamp_rate(int'(s.rate), RMAX));
  assign rate_eff     = (cycle_cnt == '0) ? rate_clamped : rate_q;
  assign last_pos     = (cycle_cnt == rate_eff - RATE_W'(1));

  assign s.input_tready = !rst && (!last_pos || !out_valid || s.output_tready);
  assign accept         = s.input_tvalid && s.input_tready;
  assign dec_ev         = accept && last_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      rate_q    <= RATE_W'(1);
    end else if (accept) begin
      if (cycle_cnt == '0) rate_q <= rate_clamped;
      cycle_cnt <= last_pos ? '0 : cycle_cnt + RATE_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    cic_lane #(
      .WIDTH     (WIDTH),
      .M         (M),
      .N         (N),
      .OUT_WIDTH (OUT_WIDTH),
      .REG_WIDTH (REG_WIDTH),
      .SHIFT_W   (SHIFT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .in_en  (accept),
      .dec_en (dec_ev),
      .sample (s.input_tdata[k*WIDTH +: WIDTH]),
      .shift  (s.shift),
      .result (lane_result[k*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  // A new word may replace the one being popped on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (dec_ev) begin
      out_data  <= lane_result;
      out_valid <= 1'b1;
    end else if (s.output_tready) begin
      out_valid <= 1'b0;
    end
  end

  assign s.output_tdata  = out_data;
  assign s.output_tvalid = out_valid;

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Bench for cic_decimator_mc: steady-state vector table, reset, backpressure,
// rate change and a randomised run against a behavioural CIC model.
module tb_cic_decimator_mc;

  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 2;
  localparam int RMAX      = 8;
  localparam int M         = 1;
  localparam int N         = 3;
  localparam int OUT_WIDTH = 16;
  localparam int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N);
  localparam int RATE_W    = $clog2(RMAX + 1);
  localparam int SHIFT_W   = $clog2(REG_WIDTH);
  localparam int CW        = CHANNELS * WIDTH;
  localparam int DW        = CHANNELS * OUT_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_d = 1'b0;
  initial forever #5 clk = ~clk;

  cic_decimator_mc_if #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .OUT_WIDTH(OUT_WIDTH),
    .RATE_W(RATE_W), .SHIFT_W(SHIFT_W)
  ) bus ();

  cic_decimator_mc #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .RMAX(RMAX),
    .M(M), .N(N), .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  longint m_int [CHANNELS][N];
  longint m_dly [CHANNELS][N][M];
  int     m_cnt;
  int     m_rate_q;

  function automatic longint wrap_rw(input longint v);
    longint span, r;
    span = longint'(1) << REG_WIDTH;
    r = v & (span - 1);
    if (r >= span / 2) r = r - span;
    return r;
  endfunction

  function automatic int clamp(input int r);
    return (r == 0) ? 1 : ((r > RMAX) ? RMAX : r);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] fmt(input longint v, input int sh);
    longint hi, lo, r;
    hi = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    lo = -hi - 1;
    r = v >>> sh;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return OUT_WIDTH'(r);
  endfunction

  function automatic logic model_last(input int rate_in);
    int eff;
    eff = (m_cnt == 0) ? clamp(rate_in) : m_rate_q;
    return m_cnt == eff - 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++)
      for (int k = 0; k < N; k++) begin
        m_int[c][k] = 0;
        for (int j = 0; j < M; j++) m_dly[c][k][j] = 0;
      end
    m_cnt = 0;
    m_rate_q = 1;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [CW-1:0] din, input int rate_in, input int shift_in);
    int eff;
    longint c, t, x;
    logic [DW-1:0] word;
    eff = (m_cnt == 0) ? clamp(rate_in) : m_rate_q;
    if (m_cnt == 0) m_rate_q = eff;
    if (m_cnt == eff - 1) begin
      word = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        c = m_int[ch][N-1];
        for (int k = 0; k < N; k++) begin
          t = wrap_rw(c - m_dly[ch][k][M-1]);
          for (int j = M - 1; j > 0; j--) m_dly[ch][k][j] = m_dly[ch][k][j-1];
          m_dly[ch][k][0] = c;
          c = t;
        end
        word[ch*OUT_WIDTH +: OUT_WIDTH] = fmt(c, shift_in);
      end
      exp_q.push_back(word);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    for (int ch = 0; ch < CHANNELS; ch++) begin
      x = longint'(signed'(din[ch*WIDTH +: WIDTH]));
      for (int k = N - 1; k > 0; k--) m_int[ch][k] = wrap_rw(m_int[ch][k] + m_int[ch][k-1]);
      m_int[ch][0] = wrap_rw(m_int[ch][0] + x);
    end
  endtask

  // ---------------- driver ----------------
  logic          last_valid;
  logic          last_pop;
  logic [DW-1:0] last_word;
  int            acc_before;
  int            n_acc = 0;

  function automatic logic [CW-1:0] pack(input int l0, input int l1);
    return {WIDTH'(l1), WIDTH'(l0)};
  endfunction

  task automatic step(input logic v, input logic [CW-1:0] din, input logic rdy,
                      input int rate_in, input int shift_in);
    logic exp_rdy;
    bus.input_tvalid  = v;
    bus.input_tdata   = din;
    bus.output_tready = rdy;
    bus.rate          = RATE_W'(rate_in);
    bus.shift         = SHIFT_W'(shift_in);
    @(negedge clk);
    last_valid = bus.output_tvalid;
    last_word  = bus.output_tdata;
    last_pop   = 1'b0;
    acc_before = n_acc;
    if (rst) begin
      check("tready_in_reset", 64'(bus.input_tready), 64'(0));
      if (rst_d) begin
        check("tvalid_in_reset", 64'(bus.output_tvalid), 64'(0));
        check("tdata_in_reset", 64'(bus.output_tdata), 64'(0));
      end
      model_reset();
    end else begin
      exp_rdy = !(model_last(rate_in) && exp_q.size() != 0 && !rdy);
      check("input_tready", 64'(bus.input_tready), 64'(exp_rdy));
      check("output_tvalid", 64'(bus.output_tvalid), 64'(exp_q.size() != 0));
      if (bus.output_tvalid && rdy && exp_q.size() != 0) begin
        last_pop = 1'b1;
        check("output_tdata", 64'(bus.output_tdata), 64'(exp_q.pop_front()));
      end
      if (v && bus.input_tready) begin
        model_accept(din, rate_in, shift_in);
        n_acc++;
      end
    end
    @(posedge clk);
    rst_d = rst;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1, 1, 0);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int rate;
    int shift;
    int l0;
    int l1;
    int e0;
    int e1;
  } vec_t;

  vec_t vecs[8];
  int   marks[$];

  initial begin
    logic [DW-1:0]        held;
    logic                 held_set;
    logic [OUT_WIDTH-1:0] act_l, exp_l;
    int got, rate_r, shift_r;

    // steady-state DC outputs: (clamped rate)^3 * x, shifted, saturated
    vecs[0] = '{rate: 4,  shift: 0, l0: 100,   l1: -3,     e0: 6400,  e1: -192};
    vecs[1] = '{rate: 8,  shift: 9, l0: 1000,  l1: -1000,  e0: 1000,  e1: -1000};
    vecs[2] = '{rate: 8,  shift: 0, l0: 1000,  l1: -1000,  e0: 32767, e1: -32768};
    vecs[3] = '{rate: 0,  shift: 0, l0: 1234,  l1: -32768, e0: 1234,  e1: -32768};
    vecs[4] = '{rate: 15, shift: 9, l0: -500,  l1: 77,     e0: -500,  e1: 77};
    vecs[5] = '{rate: 2,  shift: 3, l0: 50,    l1: -7,     e0: 50,    e1: -7};
    vecs[6] = '{rate: 8,  shift: 0, l0: 63,    l1: 64,     e0: 32256, e1: 32767};
    vecs[7] = '{rate: 3,  shift: 1, l0: -11,   l1: 11,     e0: -149,  e1: 148};

    bus.input_tvalid  = 1'b0;
    bus.input_tdata   = '0;
    bus.output_tready = 1'b1;
    bus.rate          = RATE_W'(1);
    bus.shift         = '0;
    model_reset();
    @(posedge clk);
    rst_d = 1'b1;
    #1;

    // reset held with valid input present
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, pack(5, 5), 1'b1, 4, 0);
    rst = 1'b0;
    step(1'b0, '0, 1'b1, 4, 0);
    check("ready_after_reset", 64'(bus.input_tready), 64'(1));

    // table: outputs 4..6 of each run are steady state
    foreach (vecs[v]) begin
      do_reset(2);
      got = 0;
      for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
        step(1'b1, pack(vecs[v].l0, vecs[v].l1), 1'b1, vecs[v].rate, vecs[v].shift);
        if (last_pop) begin
          got++;
          if (got >= 4) begin
            act_l = last_word[OUT_WIDTH-1:0];
            exp_l = OUT_WIDTH'(vecs[v].e0);
            check($sformatf("vec%0d_out%0d_lane0", v, got), 64'(act_l), 64'(exp_l));
            act_l = last_word[2*OUT_WIDTH-1:OUT_WIDTH];
            exp_l = OUT_WIDTH'(vecs[v].e1);
            check($sformatf("vec%0d_out%0d_lane1", v, got), 64'(act_l), 64'(exp_l));
          end
        end
      end
      check($sformatf("vec%0d_output_count", v), 64'(got), 64'(6));
    end

    // backpressure at rate 2: word held, no sample lost
    do_reset(2);
    held_set = 1'b0;
    for (int i = 0; i < 26; i++) begin
      logic rdy;
      rdy = !(i >= 6 && i < 16);
      step(1'b1, pack(i * 37 - 200, 300 - i * 11), rdy, 2, 1);
      if (!rdy && last_valid) begin
        if (!held_set) begin
          held = last_word;
          held_set = 1'b1;
        end else begin
          check("bp_hold_stable", 64'(last_word), 64'(held));
        end
      end
    end
    check("bp_word_held", 64'(held_set), 64'(1));
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 2, 1);
    check("bp_drained", 64'(exp_q.size()), 64'(0));

    // rate change 4 -> 2 after two samples of a frame
    do_reset(2);
    n_acc = 0;
    marks.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pack(i * 3, -i), 1'b1, (i < 2) ? 4 : 2, 0);
      if (last_valid) marks.push_back(acc_before);
    end
    check("rc_frames", 64'(marks.size()), 64'(3));
    if (marks.size() == 3) begin
      check("rc_frame1_end", 64'(marks[0]), 64'(4));
      check("rc_frame2_end", 64'(marks[1]), 64'(6));
      check("rc_frame3_end", 64'(marks[2]), 64'(8));
    end

    // randomised run with mid-stream reset
    do_reset(2);
    rate_r  = 3;
    shift_r = 4;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        rate_r  = $urandom_range(0, 15);
        shift_r = $urandom_range(0, 31);
      end
      rst = (i == 300 || i == 301);
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom_range(0, 3) != 0, rate_r, shift_r);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, rate_r, shift_r);
    check("random_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_decimator_mc.md
# cic_decimator_mc

Multi-channel CIC decimator. It filters CHANNELS parallel signed sample lanes through a shared N-stage integrator/comb structure. The decimation rate is selectable at runtime up to RMAX, and a runtime shift normalises the output with saturation to OUT_WIDTH. It sits between the high-rate front end (PDM/ADC capture) and the downstream FIR/feature stages, on ready/valid streams in both directions.

## Interface
- WIDTH, 16: signed input sample width per channel
- CHANNELS, 2: number of parallel lanes; all lanes share one rate and one handshake
- RMAX, 8: maximum decimation rate
- M, 1: differential delay of each comb stage (1 or 2)
- N, 3: number of integrator and comb stages
- OUT_WIDTH, 16: signed output width per channel after shift and saturation
- REG_WIDTH, derived: WIDTH+$clog2((RMAX*M)**N); internal accumulator width
- clk  in  1  sole clock
- rst  in  1  reset; synchronous, active-high
- input_tdata  in  CHANNELS*WIDTH  packed samples; lane k occupies bits [k*WIDTH +: WIDTH]
- input_tvalid  in  1  input sample valid
- input_tready  out  1  input sample accepted when valid&&ready
- output_tdata  out  CHANNELS*OUT_WIDTH  packed decimated samples, same lane order as input
- output_tvalid  out  1  output valid
- output_tready  in  1  downstream ready
- rate  in  $clog2(RMAX+1)  decimation rate; 0 is treated as 1; values above RMAX are treated as RMAX
- shift  in  $clog2(REG_WIDTH)  arithmetic right shift applied before saturation

## Operation
- Integrators: on every accepted input, each lane's N cascaded integrators update. They are REG_WIDTH two's complement, and wrap is legal and intended.
- Decimation counter: cycle_cnt counts accepted inputs from 0 to rate_q-1.
- rate_q latches the clamped rate when cycle_cnt==0 and an input is accepted. A rate change mid-frame therefore takes effect at the next frame boundary.
- Decimation event: an accepted input with cycle_cnt==rate_q-1.
  - Each lane's last integrator output passes through N comb stages, each computing y = x − x[n−M] at the decimated rate.
  - Comb delay lines advance only on decimation events.
- Output formatting per lane: the comb result is arithmetically shifted right by shift. If the result exceeds the signed OUT_WIDTH range, it saturates to 2^(OUT_WIDTH−1)−1 or −2^(OUT_WIDTH−1).
- Handshake:
  - input_tready = !rst && (cycle_cnt != rate_q-1 || !output_tvalid || output_tready). Non-final samples are never stalled.
  - output_tvalid rises with new data and holds, with output_tdata stable, until output_tready.
  - A simultaneous pop and decimation event loads the new word with no gap.
- Reset:
  - Clears integrators, comb delays, cycle_cnt, and output_tdata (to 0).
  - output_tvalid=0, rate_q=1, input_tready=0 while rst is high.
  - Reset mid-frame discards the partial frame and any pending output.
- Steady-state DC gain is (rate_q*M)^N. The first N outputs after reset or a rate change are transient.

## Timing
- Latency: output_tvalid is asserted on the clock edge that accepts the final input of a frame. The data is registered, so it is visible the cycle after acceptance.
- Throughput: one input per cycle. At rate 1, one output per cycle provided output_tready stays high.
- The shift and saturation path is combinational from the comb results into the output register. shift is sampled on the decimation event.
- Under backpressure, at most one output word is buffered. Integrators stall only on the final sample of a frame.

## Structure
- Package cic_pkg holds:
  - reg-width function clog2-based (shared with cic_decimator)
  - saturate function (signed REG_WIDTH→OUT_WIDTH)
  - rate clamp function
- Sub-module cic_lane (N integrators, N combs with M-deep delays, shift and saturate) is instantiated CHANNELS times under a generate loop.
- The top level owns cycle_cnt, rate_q, the handshake logic, and the output register.

## Test plan
- Reset: hold rst high for 3 cycles with input_tvalid=1 → input_tready=0, output_tvalid=0, output_tdata=0. After release, input_tready=1.
- DC, rate=4, shift=0: lane0=100, lane1=−3, continuous valid with tready=1 → one output per 4 inputs. From the 4th output on, lane0=6400 and lane1=−192.
- Normalise, rate=8, shift=9: lane0=1000 → steady lane0=1000 (gain 512).
  - Same input with shift=0: lane0=1000*512 saturates to 32767.
  - lane1=−1000 with shift=0 saturates to −32768.
- Backpressure at rate=2: output_tready=0 for 10 cycles → output word held stable. input_tready drops only at cycle_cnt==1. No sample is lost; the output sequence matches a reference model exactly after release.
- Rate change: switch rate 4→2 at cycle_cnt==2 → the current frame still completes after 4 inputs, and subsequent frames are 2 inputs long. rate=0 behaves as 1; rate=15 behaves as 8.
- Random stimulus, both lanes, random tvalid/tready and random rate/shift changes → bit-exact against a Python model, including integrator wrap.
